// File: rtl/sdr_init_ref_seq.sv
// sdr_init_ref_seq: SDRAM power-up initialisation and periodic AUTO REFRESH scheduler.
//
// After reset it issues T_PWR_UP NOPs, PRECHARGE-all, INIT_REF_CNT AUTO REFRESH commands and
// LOAD MODE, then raises sdr_init_done and hands the command bus to the core transfer engine.
// From then on a refresh timer logs pending refreshes. The bus is borrowed back through
// ref_req/ref_gnt, and each refresh is serviced as PRECHARGE-all followed by AUTO REFRESH.
//
// Optional build macro SDR_REF_DEBT_EN:
//   defined     - pending refreshes form a 0..8 debt counter, serviced back-to-back per grant.
//   not defined - pending is a single flag; one PRE+REF per grant.
//
// Ports:
//   sdram_clk        SDRAM clock (only clock)
//   sdram_resetn     asynchronous active-low reset
//   cfg_sdr_mode_reg mode register value driven on sdr_addr with LOAD MODE
//   cfg_ref_en       periodic refresh enable
//   ref_gnt          core engine idle, command bus handed over
//   ref_req          request for the command bus
//   cmd_own          this block drives the SDRAM command bus
//   sdr_cs_n/ras_n/cas_n/we_n, sdr_addr, sdr_ba  registered SDRAM command outputs
//   sdr_init_done    initialisation complete (level)
//   ref_overrun      one-cycle pulse, refresh interval expired with no room to log it
module sdr_init_ref_seq #(
  parameter int unsigned T_PWR_UP     = 10000,
  parameter int unsigned T_RP         = 3,
  parameter int unsigned T_RFC        = 7,
  parameter int unsigned T_MRD        = 2,
  parameter int unsigned INIT_REF_CNT = 8,
  parameter int unsigned REF_INTERVAL = 1560
) (
  input  logic        sdram_clk,
  input  logic        sdram_resetn,
  input  logic [12:0] cfg_sdr_mode_reg,
  input  logic        cfg_ref_en,
  input  logic        ref_gnt,
  output logic        ref_req,
  output logic        cmd_own,
  output logic        sdr_cs_n,
  output logic        sdr_ras_n,
  output logic        sdr_cas_n,
  output logic        sdr_we_n,
  output logic [12:0] sdr_addr,
  output logic [1:0]  sdr_ba,
  output logic        sdr_init_done,
  output logic        ref_overrun
);

  typedef enum logic [2:0] {StPwrUp, StWrp, StWrfc, StWmrd, StIdle} state_e;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CmdDesel = 4'b1111;
  localparam logic [3:0] CmdNop   = 4'b0111;
  localparam logic [3:0] CmdPre   = 4'b0010;
  localparam logic [3:0] CmdRef   = 4'b0001;
  localparam logic [3:0] CmdLmr   = 4'b0000;

  localparam logic [15:0] PwrUpLast  = 16'(T_PWR_UP);
  localparam logic [15:0] RpLast     = 16'(T_RP - 1);
  localparam logic [15:0] RfcLast    = 16'(T_RFC - 1);
  localparam logic [15:0] MrdLast    = 16'(T_MRD - 1);
  localparam logic [15:0] IntLast    = 16'(REF_INTERVAL - 1);
  localparam logic [3:0]  InitRefCnt = 4'(INIT_REF_CNT);
  localparam logic [12:0] PreAllAddr = 13'h0400;

`ifdef SDR_REF_DEBT_EN
  localparam int unsigned PendW = 4;
`else
  localparam int unsigned PendW = 1;
`endif

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [3:0]       irc_q, irc_d;
  logic [15:0]      timer_q, timer_d;
  logic [PendW-1:0] pending_q, pending_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [12:0]      addr_q, addr_d;
  logic             own_q, own_d;
  logic             init_done_q, init_done_d;
  logic             ref_req_q, ref_req_d;
  logic             overrun_q, overrun_d;
  logic             expire, dec, more;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    irc_d       = irc_q;
    pending_d   = pending_q;
    cmd_d       = CmdNop;
    addr_d      = '0;
    own_d       = own_q;
    init_done_d = init_done_q;
    overrun_d   = 1'b0;
    expire      = 1'b0;
    dec         = 1'b0;

    // Refresh interval timer; held at zero until init completes or while disabled.
    timer_d = '0;
    if (init_done_q && cfg_ref_en) begin
      if (timer_q == IntLast) begin
        expire = 1'b1;
      end else begin
        timer_d = timer_q + 16'd1;
      end
    end

    // Whether another refresh is still owed after retiring the current one.
`ifdef SDR_REF_DEBT_EN
    more = (pending_q > 4'd1) || expire;
`else
    more = 1'b0;
`endif

    unique case (state_q)
      StPwrUp: begin
        if (cnt_q == PwrUpLast) begin
          cmd_d   = CmdPre;
          addr_d  = PreAllAddr;
          cnt_d   = '0;
          state_d = StWrp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWrp: begin
        if (cnt_q == RpLast) begin
          cmd_d   = CmdRef;
          cnt_d   = '0;
          state_d = StWrfc;
          if (!init_done_q) irc_d = irc_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWrfc: begin
        if (cnt_q == RfcLast) begin
          cnt_d = '0;
          if (!init_done_q) begin
            if (irc_q == InitRefCnt) begin
              cmd_d   = CmdLmr;
              addr_d  = cfg_sdr_mode_reg;
              state_d = StWmrd;
            end else begin
              cmd_d = CmdRef;
              irc_d = irc_q + 4'd1;
            end
          end else begin
            dec = 1'b1;
            if (more) begin
              cmd_d = CmdRef;
            end else begin
              cmd_d   = CmdDesel;
              own_d   = 1'b0;
              state_d = StIdle;
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWmrd: begin
        if (cnt_q == MrdLast) begin
          cmd_d       = CmdDesel;
          cnt_d       = '0;
          own_d       = 1'b0;
          init_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StIdle: begin
        cmd_d = CmdDesel;
        if (ref_req_q && ref_gnt) begin
          cmd_d   = CmdPre;
          addr_d  = PreAllAddr;
          own_d   = 1'b1;
          cnt_d   = '0;
          state_d = StWrp;
        end
      end
      default: begin
        state_d = StPwrUp;
        cnt_d   = '0;
      end
    endcase

    // Expiry and retirement in the same cycle cancel out.
`ifdef SDR_REF_DEBT_EN
    if (expire && !dec) begin
      if (pending_q == 4'd8) overrun_d = 1'b1;
      else                   pending_d = pending_q + 4'd1;
    end else if (dec && !expire) begin
      pending_d = pending_q - 4'd1;
    end
`else
    if (expire && !dec) begin
      overrun_d = pending_q;
      pending_d = 1'b1;
    end else if (dec && !expire) begin
      pending_d = 1'b0;
    end
`endif

    ref_req_d = init_done_d && (pending_d != '0) && (state_d == StIdle);
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q     <= StPwrUp;
      cnt_q       <= '0;
      irc_q       <= '0;
      timer_q     <= '0;
      pending_q   <= '0;
      cmd_q       <= CmdDesel;
      addr_q      <= '0;
      own_q       <= 1'b1;
      init_done_q <= 1'b0;
      ref_req_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      irc_q       <= irc_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      own_q       <= own_d;
      init_done_q <= init_done_d;
      ref_req_q   <= ref_req_d;
      overrun_q   <= overrun_d;
    end
  end

  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
  assign sdr_addr      = addr_q;
  assign sdr_ba        = 2'b00;
  assign cmd_own       = own_q;
  assign ref_req       = ref_req_q;
  assign sdr_init_done = init_done_q;
  assign ref_overrun   = overrun_q;

endmodule
